// File: rtl/axi_hdr_pkg.sv
// ============================================================================
// Module   : axi_hdr_pkg
// Brief    : Shared state encoding and default widths for the header arbiter
//            and the header-insert engine it feeds.
// Revision : 1.0
// ============================================================================
`default_nettype none

package axi_hdr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OFFER = 2'd1,
        ST_BUSY  = 2'd2
    } hdr_state_e;

    localparam int HDR_DATA_WD      = 32;
    localparam int HDR_DATA_BYTE_WD = HDR_DATA_WD / 8;
    localparam int HDR_BYTE_CNT_WD  = $clog2(HDR_DATA_BYTE_WD);

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin pick: first set request at or above
//            ptr (wrapping), as a one-hot grant plus its encoded index.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int N      = 4,
    parameter int IDX_WD = $clog2(N)
) (
    input  logic [N-1:0]      req,
    input  logic [IDX_WD-1:0] ptr,
    output logic [N-1:0]      grant,
    output logic [IDX_WD-1:0] idx,
    output logic              any
);

    always_comb begin
        int pos;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        pos   = 0;
        for (int i = 0; i < N; i++) begin
            // ptr is always < N, so a single subtraction is enough to wrap
            pos = int'(ptr) + i;
            if (pos >= N) pos = pos - N;
            if (!any && req[pos]) begin
                any        = 1'b1;
                grant[pos] = 1'b1;
                idx        = IDX_WD'(pos);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/axi_stream_header_arbiter.sv
// ============================================================================
// Module   : axi_stream_header_arbiter
// Brief    : Round-robin arbiter sharing one header-insert engine between
//            N_REQ requesters; grant held until the packet's last beat.
// Revision : 1.0
// ============================================================================
`default_nettype none

module axi_stream_header_arbiter
    import axi_hdr_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int DATA_WD      = HDR_DATA_WD,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
    parameter int TIMEOUT      = 1024
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_REQ-1:0]                req_valid,
    input  logic [N_REQ*DATA_WD-1:0]        req_data,
    input  logic [N_REQ*DATA_BYTE_WD-1:0]   req_keep,
    input  logic [N_REQ*BYTE_CNT_WD-1:0]    req_byte_cnt,
    output logic [N_REQ-1:0]                req_ready,
    output logic                            hdr_valid,
    output logic [DATA_WD-1:0]              hdr_data,
    output logic [DATA_BYTE_WD-1:0]         hdr_keep,
    output logic [BYTE_CNT_WD-1:0]          hdr_byte_cnt,
    input  logic                            hdr_ready,
    input  logic                            mon_valid,
    input  logic                            mon_ready,
    input  logic                            mon_last,
    output logic [$clog2(N_REQ)-1:0]        grant_id,
    output logic                            busy,
    output logic                            err_timeout,
    output logic                            err_stray_last
);

    localparam int IDX_WD  = $clog2(N_REQ);
    localparam int WDOG_WD = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WDOG_WD-1:0] WDOG_LAST = WDOG_WD'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    hdr_state_e                 r_state, w_state_nxt;
    logic [IDX_WD-1:0]          r_ptr, w_ptr_nxt;
    logic [WDOG_WD-1:0]         r_wdog, w_wdog_nxt;
    logic [IDX_WD-1:0]          r_grant_id;
    logic [DATA_WD-1:0]         r_data;
    logic [DATA_BYTE_WD-1:0]    r_keep;
    logic [BYTE_CNT_WD-1:0]     r_byte_cnt;
    logic                       r_err_timeout;
    logic                       r_err_stray;

    logic [N_REQ-1:0]           w_grant;
    logic [IDX_WD-1:0]          w_idx;
    logic                       w_any;
    logic                       w_beat;
    logic                       w_last;
    logic                       w_capture;
    logic                       w_set_timeout;
    logic                       w_set_stray;

    function automatic logic [IDX_WD-1:0] next_idx(input logic [IDX_WD-1:0] cur);
        if (cur == IDX_WD'(N_REQ - 1)) next_idx = '0;
        else                           next_idx = cur + IDX_WD'(1);
    endfunction

    rr_arbiter #(
        .N      (N_REQ),
        .IDX_WD (IDX_WD)
    ) u_rr_arbiter (
        .req   (req_valid),
        .ptr   (r_ptr),
        .grant (w_grant),
        .idx   (w_idx),
        .any   (w_any)
    );

    assign w_beat = mon_valid & mon_ready;
    assign w_last = w_beat & mon_last;

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_wdog_nxt    = '0;
        w_capture     = 1'b0;
        w_set_timeout = 1'b0;
        w_set_stray   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_set_stray = w_last;
                if (w_any) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_OFFER;
                end
            end
            ST_OFFER: begin
                // a last beat here cannot belong to this grant's packet yet
                w_set_stray = w_last;
                if (hdr_ready) w_state_nxt = ST_BUSY;
            end
            ST_BUSY: begin
                if (w_last) begin
                    w_state_nxt = ST_IDLE;
                    w_ptr_nxt   = next_idx(r_grant_id);
                end else if (w_beat) begin
                    w_wdog_nxt = '0;
                end else if ((TIMEOUT != 0) && (r_wdog == WDOG_LAST)) begin
                    w_set_timeout = 1'b1;
                    w_state_nxt   = ST_IDLE;
                    w_ptr_nxt     = next_idx(r_grant_id);
                end else begin
                    w_wdog_nxt = r_wdog + WDOG_WD'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_wdog  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_wdog  <= w_wdog_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant_id    <= '0;
            r_data        <= '0;
            r_keep        <= '0;
            r_byte_cnt    <= '0;
            r_err_timeout <= 1'b0;
            r_err_stray   <= 1'b0;
        end else begin
            if (w_capture) begin
                r_grant_id <= w_idx;
                r_data     <= req_data[w_idx*DATA_WD +: DATA_WD];
                r_keep     <= req_keep[w_idx*DATA_BYTE_WD +: DATA_BYTE_WD];
                r_byte_cnt <= req_byte_cnt[w_idx*BYTE_CNT_WD +: BYTE_CNT_WD];
            end
            if (w_set_timeout) r_err_timeout <= 1'b1;
            if (w_set_stray)   r_err_stray   <= 1'b1;
        end
    end

    // req_ready is combinational, so it must also be masked while rst is held
    assign req_ready      = ((r_state == ST_IDLE) && !rst) ? w_grant : '0;
    assign hdr_valid      = (r_state == ST_OFFER);
    assign hdr_data       = r_data;
    assign hdr_keep       = r_keep;
    assign hdr_byte_cnt   = r_byte_cnt;
    assign grant_id       = r_grant_id;
    assign busy           = (r_state != ST_IDLE);
    assign err_timeout    = r_err_timeout;
    assign err_stray_last = r_err_stray;

endmodule

`default_nettype wire

// File: tb/tb_axi_stream_header_arbiter.sv
// ============================================================================
// Module   : tb_axi_stream_header_arbiter
// Brief    : Directed scoreboard bench for axi_stream_header_arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_axi_stream_header_arbiter;

    localparam int N_REQ = 4;
    localparam int DW    = 32;
    localparam int KW    = 4;
    localparam int CW    = 2;

    typedef struct packed {
        logic [1:0]    id;
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [CW-1:0] cnt;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [N_REQ-1:0]      req_valid = '0;
    logic [N_REQ*DW-1:0]   req_data = '0;
    logic [N_REQ*KW-1:0]   req_keep = '0;
    logic [N_REQ*CW-1:0]   req_byte_cnt = '0;
    logic [N_REQ-1:0]      req_ready;
    logic                  hdr_valid;
    logic [DW-1:0]         hdr_data;
    logic [KW-1:0]         hdr_keep;
    logic [CW-1:0]         hdr_byte_cnt;
    logic                  hdr_ready = 1'b0;
    logic                  mon_valid = 1'b0;
    logic                  mon_ready = 1'b0;
    logic                  mon_last = 1'b0;
    logic [1:0]            grant_id;
    logic                  busy;
    logic                  err_timeout;
    logic                  err_stray_last;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    axi_stream_header_arbiter #(
        .N_REQ   (N_REQ),
        .DATA_WD (DW),
        .TIMEOUT (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_keep       (req_keep),
        .req_byte_cnt   (req_byte_cnt),
        .req_ready      (req_ready),
        .hdr_valid      (hdr_valid),
        .hdr_data       (hdr_data),
        .hdr_keep       (hdr_keep),
        .hdr_byte_cnt   (hdr_byte_cnt),
        .hdr_ready      (hdr_ready),
        .mon_valid      (mon_valid),
        .mon_ready      (mon_ready),
        .mon_last       (mon_last),
        .grant_id       (grant_id),
        .busy           (busy),
        .err_timeout    (err_timeout),
        .err_stray_last (err_stray_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int i, input logic [DW-1:0] d, input logic [KW-1:0] k,
                           input logic [CW-1:0] c);
        req_data[i*DW +: DW]     = d;
        req_keep[i*KW +: KW]     = k;
        req_byte_cnt[i*CW +: CW] = c;
    endtask

    task automatic push(input logic [1:0] id, input logic [DW-1:0] d, input logic [KW-1:0] k,
                        input logic [CW-1:0] c);
        exp_t e;
        e.id = id; e.data = d; e.keep = k; e.cnt = c;
        sb.push_back(e);
    endtask

    task automatic last_beat();
        mon_valid = 1'b1; mon_ready = 1'b1; mon_last = 1'b1;
        step();
        mon_valid = 1'b0; mon_ready = 1'b0; mon_last = 1'b0;
    endtask

    // called in OFFER: accept the header, then end the packet
    task automatic finish_pkt();
        hdr_ready = 1'b1;
        step();
        hdr_ready = 1'b0;
        last_beat();
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        check({tag, "_hdr_valid"}, 64'(hdr_valid), 64'd0);
        check({tag, "_busy"},      64'(busy), 64'd0);
        check({tag, "_grant_id"},  64'(grant_id), 64'd0);
        check({tag, "_hdr_data"},  64'(hdr_data), 64'd0);
        check({tag, "_hdr_keep"},  64'(hdr_keep), 64'd0);
        check({tag, "_hdr_cnt"},   64'(hdr_byte_cnt), 64'd0);
        check({tag, "_err_to"},    64'(err_timeout), 64'd0);
        check({tag, "_err_stray"}, 64'(err_stray_last), 64'd0);
    endtask

    // scoreboard monitor: sampled mid-cycle, ahead of the edge that completes it
    always @(negedge clk) begin
        if (hdr_valid && hdr_ready && !rst) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected_hdr: got data %0h expected no header", hdr_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_grant_id", 64'(grant_id), 64'(e.id));
                check("sb_hdr_data", 64'(hdr_data), 64'(e.data));
                check("sb_hdr_keep", 64'(hdr_keep), 64'(e.keep));
                check("sb_hdr_cnt",  64'(hdr_byte_cnt), 64'(e.cnt));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected finish by 100000");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [KW-1:0] keep_tab [4];
        int            order [8];
        logic [DW-1:0] d;
        keep_tab = '{4'hF, 4'h7, 4'h3, 4'h1};
        order    = '{0, 1, 2, 3, 0, 1, 2, 3};

        // reset state
        #1;
        check_zero_outputs("reset");
        step();
        step();
        rst = 1'b0;

        // all four requesting continuously: strict rotation from 0
        req_valid = 4'hF;
        for (int p = 0; p < 8; p++) begin
            for (int i = 0; i < N_REQ; i++)
                set_req(i, 32'hC000_0000 | (p << 8) | i, keep_tab[i], CW'(i));
            #1;
            check("rr_req_ready", 64'(req_ready), 64'(1) << order[p]);
            d = 32'hC000_0000 | (p << 8) | order[p];
            push(2'(order[p]), d, keep_tab[order[p]], CW'(order[p]));
            step();
            check("rr_offer_valid", 64'(hdr_valid), 64'd1);
            check("rr_offer_rdy0", 64'(req_ready), 64'd0);
            hdr_ready = 1'b1;
            step();
            hdr_ready = 1'b0;
            check("rr_busy_no_hdr", 64'(hdr_valid), 64'd0);
            mon_valid = 1'b1; mon_ready = 1'b1;
            step();
            check("rr_busy_no_hdr2", 64'(hdr_valid), 64'd0);
            check("rr_busy_held", 64'(busy), 64'd1);
            last_beat();
            check("rr_idle", 64'(busy), 64'd0);
        end
        req_valid = '0;

        // single requester 2, one-cycle hdr latency
        set_req(2, 32'hA1B2_C3D4, 4'hF, 2'd2);
        req_valid = 4'b0100;
        #1;
        check("single_req_ready", 64'(req_ready), 64'b0100);
        push(2'd2, 32'hA1B2_C3D4, 4'hF, 2'd2);
        step();
        req_valid = '0;
        check("single_hdr_valid", 64'(hdr_valid), 64'd1);
        check("single_hdr_data", 64'(hdr_data), 64'hA1B2_C3D4);
        check("single_grant_id", 64'(grant_id), 64'd2);
        hdr_ready = 1'b1;
        step();
        hdr_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("single_busy_held", 64'(busy), 64'd1);
            step();
        end
        last_beat();
        check("single_done", 64'(busy), 64'd0);

        // back-pressure in OFFER: payload frozen, new req_data ignored
        set_req(1, 32'h55AA_1234, 4'h3, 2'd1);
        req_valid = 4'b0010;
        #1;
        check("bp_req_ready", 64'(req_ready), 64'b0010);
        push(2'd1, 32'h55AA_1234, 4'h3, 2'd1);
        step();
        set_req(1, 32'hDEAD_BEEF, 4'hF, 2'd3);
        req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            check("bp_hdr_data", 64'(hdr_data), 64'h55AA_1234);
            check("bp_hdr_keep", 64'(hdr_keep), 64'h3);
            check("bp_hdr_cnt", 64'(hdr_byte_cnt), 64'd1);
            check("bp_req_ready0", 64'(req_ready), 64'd0);
            step();
        end
        req_valid = '0;
        finish_pkt();

        // watchdog: ptr=2, requesters 0 and 3 -> 3 wins, then times out
        set_req(3, 32'h0BAD_F00D, 4'hC, 2'd0);
        req_valid = 4'b1001;
        #1;
        check("wd_req_ready", 64'(req_ready), 64'b1000);
        push(2'd3, 32'h0BAD_F00D, 4'hC, 2'd0);
        step();
        req_valid = '0;
        hdr_ready = 1'b1;
        step();
        hdr_ready = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            step();
            check("wd_still_busy", 64'(busy), 64'd1);
            check("wd_no_err_yet", 64'(err_timeout), 64'd0);
        end
        step();
        check("wd_expired_idle", 64'(busy), 64'd0);
        check("wd_err_timeout", 64'(err_timeout), 64'd1);
        set_req(0, 32'h1357_9BDF, 4'hF, 2'd3);
        req_valid = 4'hF;
        #1;
        check("wd_next_grant", 64'(req_ready), 64'b0001);
        push(2'd0, 32'h1357_9BDF, 4'hF, 2'd3);
        step();
        req_valid = '0;
        finish_pkt();

        // stray last in IDLE: flag set, pointer (now 1) unchanged
        last_beat();
        check("stray_idle_flag", 64'(err_stray_last), 64'd1);
        check("stray_idle_busy", 64'(busy), 64'd0);
        req_valid = 4'hF;
        #1;
        check("stray_idle_ptr", 64'(req_ready), 64'b0010);

        // async reset mid-OFFER (header never handshaken, so nothing pushed)
        step();
        check("arst_offer_pre", 64'(hdr_valid), 64'd1);
        rst = 1'b1;
        #1;
        check_zero_outputs("arst_offer");
        step();
        rst = 1'b0;
        #1;
        check("arst_offer_first", 64'(req_ready), 64'b0001);

        // async reset mid-BUSY
        set_req(0, 32'h2468_ACE0, 4'h7, 2'd1);
        push(2'd0, 32'h2468_ACE0, 4'h7, 2'd1);
        step();
        hdr_ready = 1'b1;
        step();
        hdr_ready = 1'b0;
        check("arst_busy_pre", 64'(busy), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        check_zero_outputs("arst_busy");
        step();
        rst = 1'b0;
        #1;
        check("arst_busy_first", 64'(req_ready), 64'b0001);

        // hdr handshake and last beat together in OFFER
        set_req(0, 32'hFEED_0001, 4'h1, 2'd2);
        req_valid = 4'b0001;
        push(2'd0, 32'hFEED_0001, 4'h1, 2'd2);
        step();
        req_valid = '0;
        hdr_ready = 1'b1;
        mon_valid = 1'b1; mon_ready = 1'b1; mon_last = 1'b1;
        step();
        hdr_ready = 1'b0;
        mon_valid = 1'b0; mon_ready = 1'b0; mon_last = 1'b0;
        check("both_busy", 64'(busy), 64'd1);
        check("both_hdr_valid", 64'(hdr_valid), 64'd0);
        check("both_stray", 64'(err_stray_last), 64'd1);
        check("both_no_timeout", 64'(err_timeout), 64'd0);
        last_beat();
        check("both_done", 64'(busy), 64'd0);
        check("both_stray_sticky", 64'(err_stray_last), 64'd1);

        step();
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
